// File: rtl/audio_tone_monitor_if.sv
// Sample stream, run control and result status of the audio tone monitor.
// The master drives samples and start; the slave (monitor) reports results.
interface audio_tone_monitor_if;
    logic               start;
    logic               smpl_vld;
    logic signed [15:0] lft_smpl;
    logic signed [15:0] rht_smpl;
    logic               busy;
    logic               done;
    logic               timeout;
    logic [7:0]         lft_freq_err;
    logic [7:0]         rht_freq_err;
    logic [7:0]         lft_ampl_err;
    logic [7:0]         rht_ampl_err;
    logic               pass;

    modport master (
        output start, smpl_vld, lft_smpl, rht_smpl,
        input  busy, done, timeout, lft_freq_err, rht_freq_err,
               lft_ampl_err, rht_ampl_err, pass
    );

    modport slave (
        input  start, smpl_vld, lft_smpl, rht_smpl,
        output busy, done, timeout, lft_freq_err, rht_freq_err,
               lft_ampl_err, rht_ampl_err, pass
    );
endinterface

// File: rtl/audio_tone_monitor.sv
// Stereo codec tone checker: settles on rising zero crossings, then checks the
// period length and signed peak of every cycle over a fixed sample window.
module audio_tone_monitor #(
    parameter int SETTLE_XINGS   = 10,
    parameter int TEST_SAMPLES   = 2000,
    parameter int MIN_PERIOD     = 12,
    parameter int MAX_PERIOD     = 20,
    parameter int MIN_AMPL       = 750,
    parameter int MAX_AMPL       = 1250,
    parameter int SETTLE_TIMEOUT = 4096
) (
    input logic                 clk,
    input logic                 RST_n,
    audio_tone_monitor_if.slave bus
);

    typedef enum logic [1:0] {IDLE, SETTLE, MEASURE, DONE} state_t;

    localparam logic        [15:0] XINGS   = 16'(SETTLE_XINGS);
    localparam logic        [15:0] PMIN    = 16'(MIN_PERIOD);
    localparam logic        [15:0] PMAX    = 16'(MAX_PERIOD);
    localparam logic signed [15:0] AMIN    = 16'(MIN_AMPL);
    localparam logic signed [15:0] AMAX    = 16'(MAX_AMPL);
    localparam logic        [31:0] TO_LAST = 32'(SETTLE_TIMEOUT - 1);
    localparam logic        [31:0] MS_LAST = 32'(TEST_SAMPLES - 1);

    state_t state, state_nxt;

    logic               start_acc;
    logic               active;
    logic               last_settle;
    logic               last_meas;
    logic               arm_both;
    logic               timeout_q;
    logic        [31:0] smpl_cnt;

    // Index 0 is the left channel, index 1 the right channel.
    logic signed [15:0] smpl     [0:1];
    logic        [15:0] per_cnt  [0:1];
    logic signed [15:0] peak     [0:1];
    logic        [15:0] xing_cnt [0:1];
    logic        [7:0]  freq_err [0:1];
    logic        [7:0]  ampl_err [0:1];
    logic        [1:0]  sign_d;
    logic        [1:0]  xing;
    logic        [1:0]  armed;
    logic        [1:0]  arm_nxt;
    logic        [1:0]  chk;
    logic        [1:0]  f_bad;
    logic        [1:0]  a_bad;

    always_comb begin
        start_acc = bus.start && (state == IDLE || state == DONE);
        active    = bus.smpl_vld && (state == SETTLE || state == MEASURE);
        smpl[0]   = bus.lft_smpl;
        smpl[1]   = bus.rht_smpl;
        xing      = '0;
        armed     = '0;
        arm_nxt   = '0;
        chk       = '0;
        f_bad     = '0;
        a_bad     = '0;
        for (int unsigned ch = 0; ch < 2; ch++) begin
            xing[ch]    = active && !smpl[ch][15] && sign_d[ch];
            armed[ch]   = (xing_cnt[ch] == XINGS);
            // Arming this edge counts, so the FSM leaves SETTLE on the arming crossing.
            arm_nxt[ch] = armed[ch] || (xing[ch] && xing_cnt[ch] == XINGS - 16'd1);
            chk[ch]     = xing[ch] && armed[ch] && (state == MEASURE);
            f_bad[ch]   = (per_cnt[ch] < PMIN) || (per_cnt[ch] > PMAX);
            a_bad[ch]   = (peak[ch] < AMIN) || (peak[ch] > AMAX);
        end
        arm_both    = &arm_nxt;
        last_settle = active && (state == SETTLE) && (smpl_cnt == TO_LAST);
        last_meas   = active && (state == MEASURE) && (smpl_cnt == MS_LAST);
    end

    always_ff @(posedge clk) begin
        if (!RST_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = SETTLE;
            SETTLE: begin
                if (arm_both)         state_nxt = MEASURE;
                else if (last_settle) state_nxt = DONE;
            end
            MEASURE: if (last_meas) state_nxt = DONE;
            DONE:    if (bus.start) state_nxt = SETTLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!RST_n || start_acc) begin
            smpl_cnt  <= '0;
            timeout_q <= 1'b0;
            sign_d    <= '0;
            for (int unsigned ch = 0; ch < 2; ch++) begin
                per_cnt[ch]  <= '0;
                peak[ch]     <= '0;
                xing_cnt[ch] <= '0;
                freq_err[ch] <= '0;
                ampl_err[ch] <= '0;
            end
        end else begin
            if (state != state_nxt)
                smpl_cnt <= '0;
            else if (active)
                smpl_cnt <= smpl_cnt + 32'd1;

            if (state == SETTLE && state_nxt == DONE)
                timeout_q <= 1'b1;

            for (int unsigned ch = 0; ch < 2; ch++) begin
                if (active) begin
                    sign_d[ch] <= smpl[ch][15];
                    if (xing[ch]) begin
                        per_cnt[ch] <= 16'd1;
                        peak[ch]    <= smpl[ch];
                        if (!armed[ch])
                            xing_cnt[ch] <= xing_cnt[ch] + 16'd1;
                    end else begin
                        if (per_cnt[ch] != '1)
                            per_cnt[ch] <= per_cnt[ch] + 16'd1;
                        if (smpl[ch] > peak[ch])
                            peak[ch] <= smpl[ch];
                    end
                end
                if (chk[ch] && f_bad[ch] && freq_err[ch] != '1)
                    freq_err[ch] <= freq_err[ch] + 8'd1;
                if (chk[ch] && a_bad[ch] && ampl_err[ch] != '1)
                    ampl_err[ch] <= ampl_err[ch] + 8'd1;
            end
        end
    end

    always_comb begin
        bus.busy         = (state == SETTLE) || (state == MEASURE);
        bus.done         = (state == DONE);
        bus.timeout      = timeout_q;
        bus.lft_freq_err = freq_err[0];
        bus.rht_freq_err = freq_err[1];
        bus.lft_ampl_err = ampl_err[0];
        bus.rht_ampl_err = ampl_err[1];
        bus.pass         = (state == DONE) && !timeout_q &&
                           (freq_err[0] == '0) && (freq_err[1] == '0) &&
                           (ampl_err[0] == '0) && (ampl_err[1] == '0);
    end

endmodule

// File: tb/tb_audio_tone_monitor.sv
// Bench for audio_tone_monitor: drives sine tones and random stimulus and
// compares results with a sample-index based model of the checking rules.
module tb_audio_tone_monitor;

    localparam int SX   = 10;
    localparam int TS   = 2000;
    localparam int MINP = 12;
    localparam int MAXP = 20;
    localparam int MINA = 750;
    localparam int MAXA = 1250;
    localparam int STO  = 4096;

    typedef int iq_t[$];

    logic clk = 1'b0;
    logic RST_n;
    always #5 clk = ~clk;

    audio_tone_monitor_if bus();

    audio_tone_monitor #(
        .SETTLE_XINGS(SX), .TEST_SAMPLES(TS), .MIN_PERIOD(MINP), .MAX_PERIOD(MAXP),
        .MIN_AMPL(MINA), .MAX_AMPL(MAXA), .SETTLE_TIMEOUT(STO)
    ) dut (
        .clk(clk),
        .RST_n(RST_n),
        .bus(bus)
    );

    int n_chk = 0;
    int n_fail = 0;
    iq_t lq, rq;
    int e_lf, e_rf, e_la, e_ra;
    bit e_to, e_pass;
    logic [31:0] e_errs;

    function automatic int tone(int k, int p, int a, int nz);
        int v;
        if (p == 0) v = a;
        else        v = int'(a * $sin(6.283185307179586 * k / p));
        if (nz > 0) v = v + int'($urandom_range(0, 2 * nz)) - nz;
        return v;
    endfunction

    function automatic iq_t crossings(input iq_t s);
        iq_t x;
        bit neg = 1'b0;
        for (int i = 0; i < s.size(); i++) begin
            if (s[i] >= 0 && neg) x.push_back(i);
            neg = (s[i] < 0);
        end
        return x;
    endfunction

    // A checked period runs from one crossing up to the sample before the next.
    function automatic void chan_errs(input iq_t s, input iq_t x, input int t,
                                      output int f, output int a);
        int per, pk;
        f = 0;
        a = 0;
        for (int k = SX; k < x.size(); k++) begin
            if (x[k] > t && x[k] <= t + TS) begin
                per = x[k] - x[k-1];
                pk  = -32768;
                for (int i = x[k-1]; i < x[k]; i++) if (s[i] > pk) pk = s[i];
                if (per < MINP || per > MAXP) f++;
                if (pk < MINA || pk > MAXA) a++;
            end
        end
        if (f > 255) f = 255;
        if (a > 255) a = 255;
    endfunction

    function automatic void model();
        iq_t xl, xr;
        int al, ar, t;
        xl = crossings(lq);
        xr = crossings(rq);
        al = (xl.size() >= SX) ? xl[SX-1] : 32'h3fff_ffff;
        ar = (xr.size() >= SX) ? xr[SX-1] : 32'h3fff_ffff;
        t  = (al > ar) ? al : ar;
        e_to = (t >= STO);
        e_lf = 0; e_rf = 0; e_la = 0; e_ra = 0;
        if (!e_to) begin
            chan_errs(lq, xl, t, e_lf, e_la);
            chan_errs(rq, xr, t, e_rf, e_ra);
        end
        e_pass = !e_to && e_lf == 0 && e_rf == 0 && e_la == 0 && e_ra == 0;
        e_errs = {8'(e_lf), 8'(e_rf), 8'(e_la), 8'(e_ra)};
    endfunction

    task automatic run_tone(input int lp, input int la, input int rp, input int ra,
                            input int nz, input int gap, input int mid_start,
                            input int max_cycles, input bit must_finish);
        int k = 0, cyc = 0, l, r, lph = 0, rph = 0;
        bit mid_done = 1'b0;
        lq.delete();
        rq.delete();
        if (nz > 0 && lp > 0) lph = $urandom_range(0, lp - 1);
        if (nz > 0 && rp > 0) rph = $urandom_range(0, rp - 1);
        bus.start    = 1'b1;
        bus.smpl_vld = 1'($urandom_range(0, 1));
        bus.lft_smpl = -16'sd500;
        bus.rht_smpl = -16'sd500;
        @(posedge clk); #1;
        bus.start = 1'b0;
        n_chk++;
        if ({bus.busy, bus.done, bus.timeout, bus.lft_freq_err, bus.rht_freq_err,
             bus.lft_ampl_err, bus.rht_ampl_err} !== {3'b100, 32'h0}) begin
            n_fail++;
            $display("FAIL start_clear: got busy=%0b done=%0b to=%0b errs=%h, want busy=1 done=0 to=0 errs=0",
                     bus.busy, bus.done, bus.timeout,
                     {bus.lft_freq_err, bus.rht_freq_err, bus.lft_ampl_err, bus.rht_ampl_err});
        end
        while (bus.done !== 1'b1 && cyc < max_cycles) begin
            if (gap > 0 && $urandom_range(0, gap) != 0) begin
                bus.smpl_vld = 1'b0;
            end else begin
                l = tone(k + lph, lp, la, nz);
                r = tone(k + rph, rp, ra, nz);
                bus.smpl_vld = 1'b1;
                bus.lft_smpl = 16'(l);
                bus.rht_smpl = 16'(r);
                lq.push_back(l);
                rq.push_back(r);
                k++;
            end
            bus.start = (mid_start > 0 && k == mid_start && !mid_done);
            if (bus.start) mid_done = 1'b1;
            @(posedge clk); #1;
            cyc++;
        end
        bus.smpl_vld = 1'b0;
        bus.start    = 1'b0;
        if (must_finish) begin
            n_chk++;
            if (bus.done !== 1'b1) begin
                n_fail++;
                $display("FAIL run_done: done=%0b after %0d cycles, want 1", bus.done, cyc);
            end
        end
    endtask

    task automatic test_reset();
        RST_n = 1'b0;
        bus.start = 1'b0;
        bus.smpl_vld = 1'b0;
        bus.lft_smpl = '0;
        bus.rht_smpl = '0;
        repeat (3) @(posedge clk);
        #1;
        RST_n = 1'b1;
        n_chk++;
        if ({bus.busy, bus.done, bus.timeout, bus.pass} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_flags: got busy/done/to/pass=%b want 0000",
                     {bus.busy, bus.done, bus.timeout, bus.pass});
        end
        n_chk++;
        if ({bus.lft_freq_err, bus.rht_freq_err, bus.lft_ampl_err, bus.rht_ampl_err} !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_errs: got %h want 00000000",
                     {bus.lft_freq_err, bus.rht_freq_err, bus.lft_ampl_err, bus.rht_ampl_err});
        end
        @(posedge clk); #1;
        n_chk++;
        if (bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: busy=%0b without start, want 0", bus.busy);
        end
    endtask

    task automatic test_good_tone(input string name, input int lp, input int la,
                                  input int rp, input int ra);
        run_tone(lp, la, rp, ra, 0, 0, 0, 6000, 1'b1);
        model();
        n_chk++;
        if ({bus.done, bus.timeout, bus.pass} !== {1'b1, e_to, e_pass}) begin
            n_fail++;
            $display("FAIL %s_flags: got done/to/pass=%b want %b", name,
                     {bus.done, bus.timeout, bus.pass}, {1'b1, e_to, e_pass});
        end
        n_chk++;
        if ({bus.lft_freq_err, bus.rht_freq_err, bus.lft_ampl_err, bus.rht_ampl_err} !== e_errs) begin
            n_fail++;
            $display("FAIL %s_errs: got lf/rf/la/ra=%h want %h", name,
                     {bus.lft_freq_err, bus.rht_freq_err, bus.lft_ampl_err, bus.rht_ampl_err}, e_errs);
        end
    endtask

    task automatic test_pass_tone();
        test_good_tone("good", 16, 1000, 16, 1000);
        n_chk++;
        if (bus.pass !== 1'b1) begin
            n_fail++;
            $display("FAIL good_pass: got %0b want 1", bus.pass);
        end
    endtask

    task automatic test_freq_err();
        test_good_tone("freq", 8, 1000, 16, 1000);
    endtask

    task automatic test_back_to_back();
        test_good_tone("b2b", 16, 1000, 16, 1000);
    endtask

    task automatic test_ampl_err();
        test_good_tone("ampl", 16, 2000, 16, 2000);
    endtask

    task automatic test_boundaries();
        test_good_tone("bound_in", 12, 1250, 20, 750);
        test_good_tone("bound_out", 11, 1000, 21, 1000);
    endtask

    task automatic test_done_hold();
        for (int i = 0; i < 60; i++) begin
            bus.smpl_vld = 1'b1;
            bus.lft_smpl = 16'(tone(i, 4, 3000, 0));
            bus.rht_smpl = 16'(tone(i, 4, 3000, 0));
            @(posedge clk); #1;
        end
        bus.smpl_vld = 1'b0;
        n_chk++;
        if ({bus.done, bus.timeout, bus.pass} !== {1'b1, e_to, e_pass}) begin
            n_fail++;
            $display("FAIL hold_flags: got done/to/pass=%b want %b",
                     {bus.done, bus.timeout, bus.pass}, {1'b1, e_to, e_pass});
        end
        n_chk++;
        if ({bus.lft_freq_err, bus.rht_freq_err, bus.lft_ampl_err, bus.rht_ampl_err} !== e_errs) begin
            n_fail++;
            $display("FAIL hold_errs: got %h want %h",
                     {bus.lft_freq_err, bus.rht_freq_err, bus.lft_ampl_err, bus.rht_ampl_err}, e_errs);
        end
    endtask

    task automatic test_timeout();
        test_good_tone("timeout", 0, 256, 0, 256);
        n_chk++;
        if (lq.size() != STO) begin
            n_fail++;
            $display("FAIL timeout_len: done after %0d samples, want %0d", lq.size(), STO);
        end
    endtask

    task automatic test_reset_mid_run();
        run_tone(8, 1000, 16, 1000, 0, 0, 0, 500, 1'b0);
        RST_n = 1'b0;
        @(posedge clk); #1;
        RST_n = 1'b1;
        n_chk++;
        if ({bus.busy, bus.done, bus.timeout, bus.pass, bus.lft_freq_err, bus.rht_freq_err,
             bus.lft_ampl_err, bus.rht_ampl_err} !== 36'h0) begin
            n_fail++;
            $display("FAIL midreset_clear: got busy/done/to/pass=%b errs=%h want all 0",
                     {bus.busy, bus.done, bus.timeout, bus.pass},
                     {bus.lft_freq_err, bus.rht_freq_err, bus.lft_ampl_err, bus.rht_ampl_err});
        end
        test_pass_tone();
    endtask

    task automatic test_saturation();
        run_tone(6, 1000, 6, 1000, 0, 0, 400, 6000, 1'b1);
        model();
        n_chk++;
        if ({bus.lft_freq_err, bus.rht_freq_err, bus.lft_ampl_err, bus.rht_ampl_err} !== e_errs) begin
            n_fail++;
            $display("FAIL sat_errs: got %h want %h",
                     {bus.lft_freq_err, bus.rht_freq_err, bus.lft_ampl_err, bus.rht_ampl_err}, e_errs);
        end
        n_chk++;
        if ({bus.lft_freq_err, bus.rht_freq_err} !== 16'hffff) begin
            n_fail++;
            $display("FAIL sat_cap: got lf=%0d rf=%0d want 255 255", bus.lft_freq_err, bus.rht_freq_err);
        end
    endtask

    task automatic test_random();
        int lp, rp, la, ra, nz, gap;
        for (int it = 0; it < 4; it++) begin
            lp  = $urandom_range(6, 24);
            rp  = $urandom_range(6, 24);
            la  = $urandom_range(500, 2100);
            ra  = $urandom_range(500, 2100);
            nz  = $urandom_range(1, 30);
            gap = $urandom_range(0, 2);
            run_tone(lp, la, rp, ra, nz, gap, 0, 15000, 1'b1);
            model();
            n_chk++;
            if ({bus.done, bus.timeout, bus.pass} !== {1'b1, e_to, e_pass}) begin
                n_fail++;
                $display("FAIL rand%0d_flags: got done/to/pass=%b want %b (lp=%0d rp=%0d)",
                         it, {bus.done, bus.timeout, bus.pass}, {1'b1, e_to, e_pass}, lp, rp);
            end
            n_chk++;
            if ({bus.lft_freq_err, bus.rht_freq_err, bus.lft_ampl_err, bus.rht_ampl_err} !== e_errs) begin
                n_fail++;
                $display("FAIL rand%0d_errs: got %h want %h (lp=%0d la=%0d rp=%0d ra=%0d)", it,
                         {bus.lft_freq_err, bus.rht_freq_err, bus.lft_ampl_err, bus.rht_ampl_err},
                         e_errs, lp, la, rp, ra);
            end
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_pass_tone();
        test_freq_err();
        test_back_to_back();
        test_ampl_err();
        test_done_hold();
        test_boundaries();
        test_timeout();
        test_reset_mid_run();
        test_saturation();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
